// File: rtl/eth_phy_10g_rx_lock_ctrl.sv
// eth_phy_10g_rx_lock_ctrl
// Receive-side link supervisor for a 10GBASE-R PCS. It measures sync-header
// and bad-block errors over fixed intervals, flags high BER and reports
// link-good status. When the link cannot be recovered it pulses a SERDES RX
// reset and a frame sync reset.
//
// Ports
//   clk                  in   single clock for all logic
//   rst                  in   synchronous active-high reset
//   serdes_rx_hdr        in   sync header, sampled every cycle
//   rx_block_lock        in   block lock from the frame sync
//   rx_bad_block         in   decoder bad-block strobe
//   serdes_rx_reset_req  out  SERDES RX reset request (registered)
//   framesync_rst        out  frame sync reset (registered)
//   rx_high_ber          out  high-BER status, updated once per interval
//   rx_status            out  link-good status
//
// state  | meaning
// -------+----------------------------------------------------------------
// HUNT   | waiting for block lock; counts intervals spent without lock
// LOCKED | block lock held; counts consecutive high-BER intervals
// RESET  | driving the SERDES/frame sync reset pulse, lock input ignored
module eth_phy_10g_rx_lock_ctrl #(
  parameter int HDR_WIDTH         = 2,
  parameter int INTERVAL_CYCLES   = 19531,
  parameter int BER_THRESHOLD     = 16,
  parameter int TIMEOUT_INTERVALS = 8,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 rx_block_lock,
  input  logic                 rx_bad_block,
  output logic                 serdes_rx_reset_req,
  output logic                 framesync_rst,
  output logic                 rx_high_ber,
  output logic                 rx_status
);

  localparam int TW = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1;
  localparam int EW = $clog2(BER_THRESHOLD + 1);
  localparam int BW = $clog2(TIMEOUT_INTERVALS + 1);
  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

  localparam logic [TW-1:0]        TIMER_LOAD = TW'(INTERVAL_CYCLES - 1);
  localparam logic [HW-1:0]        HOLD_LOAD  = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [EW-1:0]        BER_THR    = EW'(BER_THRESHOLD);
  localparam logic [BW-1:0]        TIMEOUT    = BW'(TIMEOUT_INTERVALS);
  localparam logic [HDR_WIDTH-1:0] HDR_DATA   = HDR_WIDTH'(1);
  localparam logic [HDR_WIDTH-1:0] HDR_CTRL   = HDR_WIDTH'(2);

  generate
    if (HDR_WIDTH != 2) begin : g_hdr_width_check
      $fatal(1, "eth_phy_10g_rx_lock_ctrl: HDR_WIDTH must be 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_RESET  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rr_q, rr_d;
  logic          fs_q, fs_d;
  logic          hb_q, hb_d;
  logic          status_q, status_d;

  logic          tick;
  logic          err_cyc;
  logic [EW-1:0] err_sum;
  logic          ber_hit;
  logic [BW-1:0] bad_inc;
  logic          timeout_hit;

  always_comb begin
    tick    = (timer_q == '0);
    err_cyc = ((serdes_rx_hdr != HDR_DATA) && (serdes_rx_hdr != HDR_CTRL)) || rx_bad_block;
    // Count including the current cycle, so the tick cycle's error belongs
    // to the interval it closes.
    err_sum = (err_cyc && (err_cnt_q != '1)) ? err_cnt_q + EW'(1) : err_cnt_q;
    ber_hit = (err_sum >= BER_THR);
    bad_inc = (bad_q == TIMEOUT) ? bad_q : bad_q + BW'(1);
    timeout_hit = (bad_inc == TIMEOUT);
  end

  always_comb begin
    timer_d   = tick ? TIMER_LOAD : timer_q - TW'(1);
    err_cnt_d = tick ? '0 : err_sum;
    hb_d      = tick ? ber_hit : hb_q;
    state_d   = state_q;
    bad_d     = bad_q;
    hold_d    = hold_q;
    rr_d      = rr_q;
    fs_d      = fs_q;
    status_d  = status_q;

    unique case (state_q)
      ST_HUNT: begin
        status_d = 1'b0;
        if (rx_block_lock) begin
          state_d = ST_LOCKED;
          bad_d   = '0;
        end else if (tick) begin
          if (timeout_hit) begin
            state_d = ST_RESET;
            bad_d   = '0;
            hold_d  = HOLD_LOAD;
            rr_d    = 1'b1;
            fs_d    = 1'b1;
            err_cnt_d = '0;
            hb_d    = 1'b0;
          end else begin
            bad_d = bad_inc;
          end
        end
      end

      ST_LOCKED: begin
        // Loss of lock wins over a simultaneous high-BER timeout.
        if (!rx_block_lock) begin
          state_d  = ST_HUNT;
          bad_d    = '0;
          status_d = 1'b0;
        end else if (tick) begin
          if (ber_hit) begin
            status_d = 1'b0;
            if (timeout_hit) begin
              state_d = ST_RESET;
              bad_d   = '0;
              hold_d  = HOLD_LOAD;
              rr_d    = 1'b1;
              fs_d    = 1'b1;
              err_cnt_d = '0;
              hb_d    = 1'b0;
            end else begin
              bad_d = bad_inc;
            end
          end else begin
            status_d = 1'b1;
            bad_d    = '0;
          end
        end
      end

      ST_RESET: begin
        status_d = 1'b0;
        if (hold_q == '0) begin
          state_d = ST_HUNT;
          bad_d   = '0;
          rr_d    = 1'b0;
          fs_d    = 1'b0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end

      default: begin
        state_d  = ST_HUNT;
        bad_d    = '0;
        rr_d     = 1'b0;
        fs_d     = 1'b0;
        status_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      timer_q   <= TIMER_LOAD;
      err_cnt_q <= '0;
      bad_q     <= '0;
      hold_q    <= '0;
      rr_q      <= 1'b0;
      fs_q      <= 1'b0;
      hb_q      <= 1'b0;
      status_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
      bad_q     <= bad_d;
      hold_q    <= hold_d;
      rr_q      <= rr_d;
      fs_q      <= fs_d;
      hb_q      <= hb_d;
      status_q  <= status_d;
    end
  end

  assign serdes_rx_reset_req = rr_q;
  assign framesync_rst       = fs_q;
  assign rx_high_ber         = hb_q;
  assign rx_status           = status_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_lock_ctrl.sv
// Directed bench for eth_phy_10g_rx_lock_ctrl with a 16-cycle interval,
// BER threshold 4, timeout of 3 intervals and a 4-cycle reset pulse.
// After each reset release the timer starts at 15, so interval ticks land
// on edges 16, 32, 48, ... counted from the first edge with rst low.
module tb_eth_phy_10g_rx_lock_ctrl;

  localparam int IC = 16;
  localparam int TH = 4;
  localparam int TO = 3;
  localparam int RH = 4;

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_LOCKED = 2'd1;
  localparam logic [1:0] S_RESET  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] hdr;
  logic       lock;
  logic       bad;
  logic       rr, fs, hb, stat;

  int checks   = 0;
  int failures = 0;

  eth_phy_10g_rx_lock_ctrl #(
    .HDR_WIDTH        (2),
    .INTERVAL_CYCLES  (IC),
    .BER_THRESHOLD    (TH),
    .TIMEOUT_INTERVALS(TO),
    .RESET_HOLD_CYCLES(RH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .serdes_rx_hdr      (hdr),
    .rx_block_lock      (lock),
    .rx_bad_block       (bad),
    .serdes_rx_reset_req(rr),
    .framesync_rst      (fs),
    .rx_high_ber        (hb),
    .rx_status          (stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_first;
    int         len;
    logic [1:0] hdr;
    logic       lock;
    logic       bad;
    logic       quiet;
    logic [1:0] st;
    logic       rr;
    logic       fs;
    logic       hb;
    logic       stat;
  } seg_t;

  seg_t segs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [1:0] h, input logic l, input logic b,
                     output logic saw_rr);
    hdr    = h;
    lock   = l;
    bad    = b;
    saw_rr = 1'b0;
    repeat (n) begin
      step();
      if (rr !== 1'b0) saw_rr = 1'b1;
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic e_rr,
                          input logic e_fs, input logic e_hb, input logic e_st);
    chk({tag, " state"}, 32'(dut.state_q), 32'(st));
    chk({tag, " serdes_rx_reset_req"}, 32'(rr), 32'(e_rr));
    chk({tag, " framesync_rst"}, 32'(fs), 32'(e_fs));
    chk({tag, " rx_high_ber"}, 32'(hb), 32'(e_hb));
    chk({tag, " rx_status"}, 32'(stat), 32'(e_st));
  endtask

  task automatic do_reset(input string tag);
    rst  = 1'b1;
    hdr  = 2'b01;
    lock = 1'b0;
    bad  = 1'b0;
    step();
    step();
    chk_outs({tag, " reset"}, S_HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, " reset timer"}, 32'(dut.timer_q), 32'(IC - 1));
    chk({tag, " reset err_cnt"}, 32'(dut.err_cnt_q), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic saw;
    logic exp_p;

    //            rst len hdr    lk bd qt  state     rr fs hb st
    segs[0]  = '{1'b1,  4, 2'b01, 0, 0, 1, S_HUNT,   0, 0, 0, 0};
    segs[1]  = '{1'b0,  1, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 0, 0};
    segs[2]  = '{1'b0, 10, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 0, 0};
    segs[3]  = '{1'b0,  1, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};
    segs[4]  = '{1'b0, 16, 2'b10, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};
    segs[5]  = '{1'b0,  3, 2'b00, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};
    segs[6]  = '{1'b0, 13, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};
    segs[7]  = '{1'b0,  3, 2'b01, 1, 1, 1, S_LOCKED, 0, 0, 0, 1};
    segs[8]  = '{1'b0, 13, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};
    segs[9]  = '{1'b0,  5, 2'b11, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};
    segs[10] = '{1'b0, 11, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 1, 0};
    segs[11] = '{1'b0,  5, 2'b00, 1, 0, 1, S_LOCKED, 0, 0, 1, 0};
    segs[12] = '{1'b0, 11, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 1, 0};
    segs[13] = '{1'b0,  5, 2'b11, 1, 0, 1, S_LOCKED, 0, 0, 1, 0};
    segs[14] = '{1'b0, 11, 2'b01, 1, 0, 0, S_RESET,  1, 1, 0, 0};
    segs[15] = '{1'b0,  3, 2'b01, 1, 0, 0, S_RESET,  1, 1, 0, 0};
    segs[16] = '{1'b0,  1, 2'b01, 1, 0, 0, S_HUNT,   0, 0, 0, 0};
    segs[17] = '{1'b0,  1, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 0, 0};
    segs[18] = '{1'b1,  3, 2'b11, 1, 1, 1, S_LOCKED, 0, 0, 0, 0};
    segs[19] = '{1'b0, 13, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};
    segs[20] = '{1'b0,  4, 2'b00, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};
    segs[21] = '{1'b0, 12, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 1, 0};
    segs[22] = '{1'b0, 16, 2'b01, 1, 0, 1, S_LOCKED, 0, 0, 0, 1};

    rst  = 1'b1;
    hdr  = 2'b01;
    lock = 1'b0;
    bad  = 1'b0;

    for (int i = 0; i < 23; i++) begin
      if (segs[i].rst_first) do_reset($sformatf("seg%0d", i));
      run(segs[i].len, segs[i].hdr, segs[i].lock, segs[i].bad, saw);
      chk_outs($sformatf("seg%0d", i), segs[i].st, segs[i].rr, segs[i].fs,
               segs[i].hb, segs[i].stat);
      if (segs[i].quiet) chk($sformatf("seg%0d no reset pulse", i), 32'(saw), 32'd0);
    end

    // Continuous errors: counter saturates, then lock drops on the third
    // high-BER tick, which must go to HUNT without a reset pulse.
    do_reset("sat");
    run(3, 2'b00, 1'b1, 1'b0, saw);
    chk("sat err_cnt after 3", 32'(dut.err_cnt_q), 32'd3);
    run(12, 2'b00, 1'b1, 1'b0, saw);
    chk("sat err_cnt saturated", 32'(dut.err_cnt_q), 32'd7);
    run(1, 2'b00, 1'b1, 1'b0, saw);
    chk_outs("sat tick1", S_LOCKED, 1'b0, 1'b0, 1'b1, 1'b0);
    run(31, 2'b00, 1'b1, 1'b0, saw);
    chk_outs("drop before tick3", S_LOCKED, 1'b0, 1'b0, 1'b1, 1'b0);
    run(1, 2'b00, 1'b0, 1'b0, saw);
    chk_outs("drop at tick3", S_HUNT, 1'b0, 1'b0, 1'b1, 1'b0);
    run(6, 2'b01, 1'b0, 1'b0, saw);
    chk("drop no reset pulse", 32'(saw), 32'd0);

    // No lock at all: a 4-cycle reset pulse after every third tick.
    do_reset("hunt");
    for (int e = 1; e <= 100; e++) begin
      run(1, 2'b01, 1'b0, 1'b0, saw);
      exp_p = ((e >= 48) && (e <= 51)) || ((e >= 96) && (e <= 99));
      chk($sformatf("hunt e%0d serdes_rx_reset_req", e), 32'(rr), 32'(exp_p));
      chk($sformatf("hunt e%0d framesync_rst", e), 32'(fs), 32'(exp_p));
      chk($sformatf("hunt e%0d state", e), 32'(dut.state_q),
          32'(exp_p ? S_RESET : S_HUNT));
    end

    // rst during the second cycle of a reset pulse truncates it.
    do_reset("trunc");
    run(49, 2'b01, 1'b0, 1'b0, saw);
    chk_outs("trunc pulse cycle2", S_RESET, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_outs("trunc after rst", S_HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    run(47, 2'b01, 1'b0, 1'b0, saw);
    chk("trunc no pulse before timeout", 32'(saw), 32'd0);
    run(1, 2'b01, 1'b0, 1'b0, saw);
    chk_outs("trunc new pulse", S_RESET, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_rx_lock_ctrl.md
ETH_PHY_10G_RX_LOCK_CTRL -- requirements
Module: eth_phy_10g_rx_lock_ctrl

Interface
REQ-001 SHALL have parameter HDR_WIDTH, default 2, sync header width; any other value is a fatal elaboration error.
REQ-002 SHALL have parameter INTERVAL_CYCLES, default 19531, measurement interval length in clocks (125 us at 156.25 MHz).
REQ-003 SHALL have parameter BER_THRESHOLD, default 16, errors per interval that flag high BER.
REQ-004 SHALL have parameter TIMEOUT_INTERVALS, default 8, consecutive bad intervals that force a SERDES reset.
REQ-005 SHALL have parameter RESET_HOLD_CYCLES, default 16, reset pulse length in clocks.
REQ-006 SHALL have port clk  input  1  single clock for all logic.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port serdes_rx_hdr  input  HDR_WIDTH  sync header, sampled every cycle.
REQ-009 SHALL have port rx_block_lock  input  1  block lock from the frame sync.
REQ-010 SHALL have port rx_bad_block  input  1  decoder bad-block strobe.
REQ-011 SHALL have port serdes_rx_reset_req  output  1  SERDES RX reset request.
REQ-012 SHALL have port framesync_rst  output  1  frame sync reset.
REQ-013 SHALL have port rx_high_ber  output  1  high-BER status.
REQ-014 SHALL have port rx_status  output  1  link-good status.

Function
REQ-015 SHALL run a free-running interval timer that counts INTERVAL_CYCLES-1 down to 0 and reloads; tick = 1 in the cycle the timer is 0.
REQ-016 SHALL define an error cycle as (hdr not 2'b01 and not 2'b10) OR rx_bad_block; each cycle adds at most 1.
REQ-017 SHALL use an error counter of width clog2(BER_THRESHOLD+1) that saturates at all-ones.
REQ-018 SHALL, on tick, set rx_high_ber = (count incl. current cycle >= BER_THRESHOLD) and reload the counter to 0; the tick cycle's error counts in the closing interval.
REQ-019 SHALL implement FSM states HUNT, LOCKED, RESET; all outputs are registered.
REQ-020 SHALL, in HUNT, go to LOCKED the cycle after rx_block_lock=1; otherwise increment bad_intervals on each tick.
REQ-021 SHALL, in HUNT, go to RESET when bad_intervals reaches TIMEOUT_INTERVALS; bad_intervals saturates and is cleared on every state change.
REQ-022 SHALL, in LOCKED, go to HUNT the cycle after rx_block_lock=0, deasserting rx_status in that same registered update.
REQ-023 SHALL, in LOCKED, increment bad_intervals on ticks that set rx_high_ber, clear it on ticks that clear rx_high_ber, and go to RESET at TIMEOUT_INTERVALS.
REQ-024 SHALL set rx_status to 1 only in LOCKED on a tick with rx_high_ber result 0; it clears on a high-BER tick or on leaving LOCKED.
REQ-025 SHALL, in RESET, hold serdes_rx_reset_req=1 and framesync_rst=1 for exactly RESET_HOLD_CYCLES cycles, then deassert both and enter HUNT; error counter and rx_high_ber are cleared on entry.
REQ-026 SHALL give loss of lock priority over a timeout when both occur in LOCKED in the same cycle (next state HUNT).
REQ-027 SHALL ignore rx_block_lock while in RESET.

Reset
REQ-028 SHALL, on rst, enter HUNT with every counter at 0, the interval timer at INTERVAL_CYCLES-1, and all outputs 0; rst overrides everything, including an in-progress RESET pulse, which is truncated.

Verification
REQ-029 SHALL, with params (16, 4, 3, 4), constant valid hdr and lock rising at cycle 5 -> LOCKED at cycle 6, rx_status=1 after first tick, serdes_rx_reset_req never 1.
REQ-030 SHALL, with lock held 0 -> serdes_rx_reset_req and framesync_rst high for exactly 4 cycles after the 3rd tick, then HUNT, repeating every 3 intervals.
REQ-031 SHALL, with 5 invalid hdrs per interval while locked -> rx_high_ber=1 and rx_status=0 at tick; after 3 such intervals RESET; with 3 per interval -> rx_high_ber stays 0.
REQ-032 SHALL, with lock dropped on the same cycle as the 3rd high-BER tick -> HUNT taken, no reset pulse.
REQ-033 SHALL, with rst asserted during the 2nd cycle of a RESET pulse -> both reset outputs 0 next cycle, state HUNT.
REQ-034 SHALL, with 20 errors in one interval -> counter saturates at 7 and rx_high_ber=1 at tick.
